// File: rtl/isa_types.sv
// Shared ISA-level types and constants for the load/store path.
package isa_types;

    localparam int XLEN   = 32;
    localparam int NBYTES = XLEN / 8;

    typedef logic [4:0] rv_reg_t;

    // Access width. Loads and stores share one encoding.
    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2
    } write_width_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ISSUE,
        LSU_WAIT,
        LSU_RESP
    } lsu_state_t;

    // One memory-port request as launched from ISSUE.
    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [NBYTES-1:0] be;
        logic [XLEN-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: byte enables, store replication, load extraction
// with sign/zero extension, and the misalignment flag. Purely combinational.
module mem_lane_align
    import isa_types::*;
#(
    parameter int XLEN   = 32,
    parameter int NBYTES = XLEN / 8,
    parameter int OFFW   = $clog2(NBYTES)
) (
    input  write_width_t      i_width,
    input  logic              i_unsigned,
    input  logic [OFFW-1:0]   i_off,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [NBYTES-1:0] o_be,
    output logic [XLEN-1:0]   o_wdata,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_misalign
);

    logic [XLEN-1:0] w_lane;
    logic            w_sext;

    // Shift the addressed byte down to bit 0 of the read word.
    assign w_lane = i_rdata >> {i_off, 3'b000};
    assign w_sext = ~i_unsigned;

    // Width-dependent lane steering and extension.
    always_comb begin
        o_be       = '0;
        o_wdata    = '0;
        o_rdata    = '0;
        o_misalign = 1'b0;
        case (i_width)
            WIDTH_BYTE: begin
                o_be    = NBYTES'(1) << i_off;
                o_wdata = {NBYTES{i_wdata[7:0]}};
                o_rdata = {{(XLEN-8){w_sext & w_lane[7]}}, w_lane[7:0]};
            end
            WIDTH_HALF: begin
                o_be       = NBYTES'(3) << i_off;
                o_wdata    = {(NBYTES/2){i_wdata[15:0]}};
                o_rdata    = {{(XLEN-16){w_sext & w_lane[15]}}, w_lane[15:0]};
                o_misalign = i_off[0];
            end
            WIDTH_WORD: begin
                o_be       = '1;
                o_wdata    = i_wdata;
                o_rdata    = w_lane;
                o_misalign = |i_off;
            end
            // Unused encoding: fault it rather than touch memory.
            default: o_misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one request from execute, runs the memory
// request/grant/response handshake and returns the result to writeback.
module mem_access_unit
    import isa_types::*;
#(
    parameter int XLEN   = 32,
    parameter int NBYTES = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  write_width_t      req_width,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  rv_reg_t           req_rd,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [NBYTES-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output rv_reg_t           resp_rd,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_fault
);

    localparam int OFFW = $clog2(NBYTES);

    lsu_state_t      r_state, w_next;
    logic            r_is_store;
    write_width_t    r_width;
    logic            r_unsigned;
    logic [OFFW-1:0] r_off;
    rv_reg_t         r_rd;
    mem_req_t        r_mem;
    logic [XLEN-1:0] r_rdata;
    logic            r_fault;

    write_width_t      w_al_width;
    logic              w_al_unsigned;
    logic [OFFW-1:0]   w_al_off;
    logic [NBYTES-1:0] w_be;
    logic [XLEN-1:0]   w_wlane;
    logic [XLEN-1:0]   w_rext;
    logic              w_misalign;
    logic              w_accept;
    logic              w_load_done;

    assign w_accept    = (r_state == LSU_IDLE) && req_valid;
    assign w_load_done = (r_state == LSU_WAIT) && mem_rvalid;

    // The aligner sees the live request in IDLE and the latched one afterwards.
    always_comb begin
        if (r_state == LSU_IDLE) begin
            w_al_width    = req_width;
            w_al_unsigned = req_unsigned;
            w_al_off      = req_addr[OFFW-1:0];
        end else begin
            w_al_width    = r_width;
            w_al_unsigned = r_unsigned;
            w_al_off      = r_off;
        end
    end

    mem_lane_align #(
        .XLEN   (XLEN),
        .NBYTES (NBYTES)
    ) u_align (
        .i_width    (w_al_width),
        .i_unsigned (w_al_unsigned),
        .i_off      (w_al_off),
        .i_wdata    (req_wdata),
        .i_rdata    (mem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wlane),
        .o_rdata    (w_rext),
        .o_misalign (w_misalign)
    );

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= LSU_IDLE;
        else       r_state <= w_next;
    end

    // Request latch on accept, load result capture on response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_store <= 1'b0;
            r_width    <= WIDTH_BYTE;
            r_unsigned <= 1'b0;
            r_off      <= '0;
            r_rd       <= '0;
            r_mem      <= '0;
            r_rdata    <= '0;
            r_fault    <= 1'b0;
        end else if (w_accept) begin
            r_is_store  <= req_is_store;
            r_width     <= req_width;
            r_unsigned  <= req_unsigned;
            r_off       <= req_addr[OFFW-1:0];
            r_rd        <= req_rd;
            r_fault     <= w_misalign;
            r_rdata     <= '0;
            r_mem.we    <= req_is_store;
            r_mem.addr  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            // Byte enables and write data only matter for stores.
            r_mem.be    <= req_is_store ? w_be : '0;
            r_mem.wdata <= req_is_store ? w_wlane : '0;
        end else if (w_load_done) begin
            r_rdata <= r_is_store ? '0 : w_rext;
        end
    end

    // Next-state and output decode; outputs are idle-zero outside their state.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_rd    = '0;
        resp_rdata = '0;
        resp_fault = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = w_misalign ? LSU_RESP : LSU_ISSUE;
            end
            LSU_ISSUE: begin
                mem_req   = 1'b1;
                mem_we    = r_mem.we;
                mem_addr  = r_mem.addr;
                mem_be    = r_mem.be;
                mem_wdata = r_mem.wdata;
                if (mem_gnt) w_next = LSU_WAIT;
            end
            LSU_WAIT: begin
                if (mem_rvalid) w_next = LSU_RESP;
            end
            LSU_RESP: begin
                resp_valid = 1'b1;
                resp_rd    = r_is_store ? '0 : r_rd;
                resp_rdata = r_rdata;
                resp_fault = r_fault;
                if (resp_ready) w_next = LSU_IDLE;
            end
            default: w_next = LSU_IDLE;
        endcase
    end

endmodule
